// File: rtl/servo_motion_ctrl.sv
// servo_motion_ctrl: slews the PWM angle toward accepted targets one bounded step per frame,
// then holds for a settle interval before signalling done.
module servo_motion_ctrl #(
  parameter int PERIOD_CYCLES = 1000000,
  parameter int STEP_DEG      = 2,
  parameter int MAX_ANGLE     = 180,
  parameter int SETTLE_FRAMES = 10,
  parameter int INIT_ANGLE    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_angle,
  output logic       cmd_ready,
  output logic [7:0] angle,
  output logic       frame_start,
  output logic       busy,
  output logic       done,
  output logic       clamped
);
  localparam int CW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
  localparam int SW = SETTLE_FRAMES > 0 ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [7:0] MAX_A  = 8'(MAX_ANGLE);
  localparam logic [7:0] STEP   = 8'(STEP_DEG);
  localparam logic [7:0] INIT_A = 8'(INIT_ANGLE);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [7:0]    angle_q, angle_d, target_q, target_d;
  logic [7:0]    clamp_angle, diff, stp, next_angle;
  logic          fs_q, fs_d, done_q, done_d, clamped_q, clamped_d, up, accept;

  always_comb begin
    cnt_d       = cnt_q == CW'(PERIOD_CYCLES - 1) ? '0 : cnt_q + CW'(1);
    fs_d        = cnt_d == '0;
    accept      = cmd_valid && state_q != MOVE;
    clamp_angle = cmd_angle > MAX_A ? MAX_A : cmd_angle;
    up          = target_q > angle_q;
    diff        = up ? target_q - angle_q : angle_q - target_q;
    stp         = diff < STEP ? diff : STEP;
    next_angle  = up ? angle_q + stp : angle_q - stp;
    state_d     = state_q;
    angle_d     = angle_q;
    target_d    = target_q;
    settle_d    = settle_q;
    done_d      = 1'b0;
    clamped_d   = 1'b0;
    // An accept outranks both stepping and settle counting.
    if (accept) begin
      target_d  = clamp_angle;
      clamped_d = cmd_angle > MAX_A;
      settle_d  = '0;
      state_d   = clamp_angle == angle_q ? SETTLE : MOVE;
    end else if (state_q == MOVE && fs_q) begin
      angle_d = next_angle;
      state_d = next_angle == target_q ? SETTLE : MOVE;
    end else if (state_q == SETTLE) begin
      done_d   = settle_q == SW'(SETTLE_FRAMES);
      state_d  = done_d ? IDLE : SETTLE;
      settle_d = !done_d && fs_q ? settle_q + SW'(1) : settle_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      settle_q  <= '0;
      angle_q   <= INIT_A;
      target_q  <= INIT_A;
      fs_q      <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      angle_q   <= angle_d;
      target_q  <= target_d;
      fs_q      <= fs_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
    end
  end

  assign cmd_ready   = state_q != MOVE;
  assign busy        = state_q != IDLE;
  assign angle       = angle_q;
  assign frame_start = fs_q;
  assign done        = done_q;
  assign clamped     = clamped_q;
endmodule

// File: tb/tb_servo_motion_ctrl.sv
// tb_servo_motion_ctrl: directed scenarios for servo_motion_ctrl with a short PWM frame.
module tb_servo_motion_ctrl;
  localparam int P = 100, STEP = 2, SF = 3, MAXA = 180;

  logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic [7:0] cmd_angle = '0;
  logic       cmd_ready, frame_start, busy, done, clamped;
  logic [7:0] angle;
  int         checks = 0, errors = 0, done_seen = 0;
  logic [7:0] max_angle = '0;

  servo_motion_ctrl #(.PERIOD_CYCLES(P), .STEP_DEG(STEP), .MAX_ANGLE(MAXA),
                      .SETTLE_FRAMES(SF), .INIT_ANGLE(0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_angle(cmd_angle),
    .cmd_ready(cmd_ready), .angle(angle), .frame_start(frame_start),
    .busy(busy), .done(done), .clamped(clamped));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_seen++;
    if (angle > max_angle) max_angle <= angle;
  end

  task automatic next_frame;
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!frame_start && n < 2 * P);
    if (!frame_start) begin
      errors++;
      $display("FAIL frame_timeout: no frame_start within %0d cycles", 2 * P);
    end
  endtask

  task automatic send_cmd(input logic [7:0] a);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_angle = a;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_angle = 8'($urandom);
  endtask

  task automatic settle_wait(output int f, output bit seen);
    f = int'(frame_start);
    seen = 1'b0;
    for (int n = 0; n < (SF + 2) * P; n++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
      if (frame_start) f++;
    end
  endtask

  task automatic test_reset;
    int n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (angle !== 8'd0) begin errors++; $display("FAIL reset_angle: got %0d expected 0", angle); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    checks++; if ({busy, done, clamped, frame_start} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, clamped, frame_start}); end
    @(negedge clk) rst_n = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!frame_start && n < 2 * P);
    checks++; if (n !== P || !frame_start) begin errors++; $display("FAIL first_frame: got %0d cycles expected %0d", n, P); end
  endtask

  task automatic test_move_up;
    int f, d0; bit seen; logic [7:0] exp = 8'd0;
    send_cmd(8'd10);
    checks++; if ({busy, cmd_ready, clamped} !== 3'b100) begin
      errors++; $display("FAIL up_accept: got busy/ready/clamped %b expected 100", {busy, cmd_ready, clamped}); end
    for (int i = 0; i < 5; i++) begin
      exp += 8'(STEP);
      next_frame;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL up_ready_move: got %b expected 0", cmd_ready); end
      @(posedge clk); #1;
      checks++; if (angle !== exp) begin errors++; $display("FAIL up_angle: got %0d expected %0d", angle, exp); end
    end
    d0 = done_seen;
    settle_wait(f, seen);
    checks++; if (!seen || f != SF) begin errors++; $display("FAIL up_settle: got done=%0b frames=%0d expected 1/%0d", seen, f, SF); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_idle: got busy %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || done_seen - d0 != 1) begin
      errors++; $display("FAIL up_done_pulse: got done=%b count=%0d expected 0/1", done, done_seen - d0); end
  endtask

  task automatic test_move_down;
    int f; bit seen; logic [7:0] exp = 8'd10;
    send_cmd(8'd5);
    for (int i = 0; i < 3; i++) begin
      exp = exp - 8'd5 > 8'(STEP) ? exp - 8'(STEP) : 8'd5;
      next_frame;
      @(posedge clk); #1;
      checks++; if (angle !== exp) begin errors++; $display("FAIL down_angle: got %0d expected %0d", angle, exp); end
    end
    settle_wait(f, seen);
    checks++; if (!seen || f != SF || angle !== 8'd5) begin
      errors++; $display("FAIL down_settle: got done=%0b frames=%0d angle=%0d expected 1/%0d/5", seen, f, angle, SF); end
  endtask

  task automatic test_equal;
    int f; bit seen;
    send_cmd(8'd5);
    checks++; if ({busy, cmd_ready} !== 2'b11) begin errors++; $display("FAIL eq_settle_state: got busy/ready %b expected 11", {busy, cmd_ready}); end
    settle_wait(f, seen);
    checks++; if (!seen || f != SF || angle !== 8'd5) begin
      errors++; $display("FAIL eq_done: got done=%0b frames=%0d angle=%0d expected 1/%0d/5", seen, f, angle, SF); end
  endtask

  task automatic test_clamp;
    int f; bit seen; logic [7:0] exp = 8'd5;
    send_cmd(8'd210);
    checks++; if (clamped !== 1'b1) begin errors++; $display("FAIL clamp_pulse: got %b expected 1", clamped); end
    @(posedge clk); #1;
    checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL clamp_width: got %b expected 0", clamped); end
    while (exp != 8'(MAXA)) begin
      exp = 8'(MAXA) - exp > 8'(STEP) ? exp + 8'(STEP) : 8'(MAXA);
      next_frame;
      @(posedge clk); #1;
      checks++; if (angle !== exp) begin errors++; $display("FAIL clamp_angle: got %0d expected %0d", angle, exp); end
    end
    settle_wait(f, seen);
    checks++; if (!seen || angle !== 8'(MAXA) || max_angle > 8'(MAXA)) begin
      errors++; $display("FAIL clamp_final: got done=%0b angle=%0d peak=%0d expected 1/180/<=180", seen, angle, max_angle); end
  endtask

  task automatic test_reset_mid_move;
    int n = 0;
    send_cmd(8'd0);
    while (angle !== 8'd50 && n < 80 * P) begin @(posedge clk); #1; n++; end
    checks++; if (angle !== 8'd50 || busy !== 1'b1) begin errors++; $display("FAIL rst_reach50: got %0d busy %b expected 50/1", angle, busy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (angle !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async: got angle=%0d busy=%b ready=%b expected 0/0/1", angle, busy, cmd_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_frame;
    @(posedge clk); #1;
    checks++; if (angle !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_discard: got angle=%0d busy=%b expected 0/0", angle, busy); end
  endtask

  task automatic test_retarget;
    int f, d0; bit seen; logic [7:0] exp = 8'd0;
    send_cmd(8'd20);
    while (exp != 8'd20) begin
      exp += 8'(STEP);
      next_frame;
      @(posedge clk); #1;
      checks++; if (angle !== exp) begin errors++; $display("FAIL rt_angle20: got %0d expected %0d", angle, exp); end
    end
    d0 = done_seen;
    next_frame;
    send_cmd(8'd40);
    checks++; if ({busy, cmd_ready} !== 2'b10) begin errors++; $display("FAIL rt_accept: got busy/ready %b expected 10", {busy, cmd_ready}); end
    while (exp != 8'd40) begin
      exp += 8'(STEP);
      next_frame;
      @(posedge clk); #1;
      checks++; if (angle !== exp) begin errors++; $display("FAIL rt_angle40: got %0d expected %0d", angle, exp); end
    end
    settle_wait(f, seen);
    checks++; if (!seen || f != SF) begin errors++; $display("FAIL rt_settle: got done=%0b frames=%0d expected 1/%0d", seen, f, SF); end
    @(posedge clk); #1;
    checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL rt_done_count: got %0d expected 1", done_seen - d0); end
  endtask

  initial begin
    test_reset;
    test_move_up;
    test_move_down;
    test_equal;
    test_clamp;
    test_reset_mid_move;
    test_retarget;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/servo_motion_ctrl.md
Name: servo_motion_ctrl

Overview:
- Sequences the servo PWM datapath. Accepts target-angle commands over a valid/ready handshake and slews the commanded angle toward each target in fixed steps.
- Each step is applied only at a PWM frame boundary, so no pulse is ever truncated or stretched mid-frame.
- Drives the angle input of the PWM generator and flags completion after a settle interval.
- Sits between the switch/host command logic and the PWM generator.

Parameters:
- PERIOD_CYCLES, 1000000, clock cycles per PWM frame (20 ms at 50 MHz); must match the PWM generator period.
- STEP_DEG, 2, maximum angle change per frame, in degrees (1..255).
- MAX_ANGLE, 180, upper clamp for commanded angle, in degrees.
- SETTLE_FRAMES, 10, frames held at target before done is raised (0 = done immediately on arrival).
- INIT_ANGLE, 0, angle driven out of reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_angle  in  8  target angle in degrees
- cmd_ready  out  1  controller accepts a command this cycle
- angle  out  8  current commanded angle to the PWM generator
- frame_start  out  1  one-cycle pulse on the first cycle of each PWM frame
- busy  out  1  high in MOVE or SETTLE
- done  out  1  one-cycle pulse when SETTLE completes
- clamped  out  1  one-cycle pulse when an accepted cmd_angle exceeded MAX_ANGLE

Behaviour:
- Reset (async assert, sync release): frame counter = 0, angle = INIT_ANGLE, target = INIT_ANGLE, state = IDLE, settle counter = 0. Outputs at reset: cmd_ready = 1, busy = 0, done = 0, clamped = 0, frame_start = 0.
- Frame counter:
  - Counts 0..PERIOD_CYCLES-1, then wraps to 0.
  - frame_start = 1 exactly when counter == 0, except during the first counter==0 after reset (registered; first pulse occurs PERIOD_CYCLES cycles after reset release).
  - Free-running in all states.
- Handshake:
  - A command is accepted on a rising clk where cmd_valid && cmd_ready.
  - cmd_ready = 1 in IDLE and in SETTLE, and 0 in MOVE.
  - cmd_angle may change freely when not accepted.
- On accept:
  - target <= min(cmd_angle, MAX_ANGLE).
  - clamped pulses the following cycle if cmd_angle > MAX_ANGLE.
  - The settle counter clears.
  - Next state is MOVE, or SETTLE if the clamped target equals the current angle.
  - A new accept during SETTLE retargets and restarts the sequence; no done is emitted for the abandoned command.
- IDLE: angle holds; busy = 0.
- MOVE:
  - On each frame_start cycle, angle steps toward target by min(STEP_DEG, |target-angle|).
  - Compute in 9 bits; no overshoot, no wrap below 0 or above MAX_ANGLE.
  - When the updated angle equals target, go to SETTLE on the next cycle.
  - angle changes only on frame_start cycles.
- SETTLE:
  - Settle counter increments on each frame_start.
  - When the count reaches SETTLE_FRAMES, pulse done for one cycle and go to IDLE.
  - If SETTLE_FRAMES = 0, done pulses on the cycle after entering SETTLE.
- Simultaneous events: an accept and frame_start in the same cycle in SETTLE give the accept priority; the settle count is not incremented.
- Reset mid-move: angle returns immediately to INIT_ANGLE (async); any in-flight command is discarded.
- busy = (state != IDLE). done and clamped are never high in the same cycle as reset deassertion.

Test Plan:
- Reset → angle=0, cmd_ready=1, busy=0. First frame_start occurs at cycle 1000000 after release. Use PERIOD_CYCLES=100 in sim for all cases.
- cmd_angle=10, STEP_DEG=2, SETTLE_FRAMES=3 → angle goes 2,4,6,8,10 on five successive frame_starts. cmd_ready is low during MOVE. done pulses once, 3 frames after reaching 10, then IDLE.
- From angle=10, cmd_angle=5 with STEP_DEG=2 → angle goes 8,6,5 (final partial step, no undershoot). Then settle and done.
- cmd_angle=210 → clamped pulses once; angle ramps to 180 and stops; never exceeds 180.
- Retarget during SETTLE (cmd_angle=40 issued while settling at 20) → accepted immediately; no done for the 20 target; ramps to 40 and emits exactly one done.
- rst_n pulsed low mid-MOVE at angle=50 → angle=0 asynchronously, state IDLE. Also check cmd_angle equal to current angle → SETTLE directly, done after SETTLE_FRAMES, angle unchanged.
